// File: rtl/adder_pkg.sv
// Shared constants and result type for the pipelined adder and its collector.
// Both blocks take their default widths and latency from here.
package adder_pkg;

  localparam int ADDER_N_DEFAULT         = 8;
  localparam int ADDER_STAGES_DEFAULT    = 2;
  localparam int COLLECTOR_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic                       cout;
    logic [ADDER_N_DEFAULT-1:0] sum;
  } adder_result_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adder_result_fifo.sv
// Small synchronous result FIFO; push and pop may coincide at any fill level.
// A pop when full frees the slot that a simultaneous push uses.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_N_DEFAULT + 1,
  parameter int DEPTH = COLLECTOR_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero when empty so the idle output is deterministic.
  assign data_o = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy next-state; pointers wrap on power-of-two depth.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/adder_result_collector.sv
// Tracks real issues through the fixed-latency adder and queues their results.
// Credit-based in_ready guarantees every tagged result has a FIFO slot.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int N      = ADDER_N_DEFAULT,
  parameter int STAGES = ADDER_STAGES_DEFAULT,
  parameter int DEPTH  = COLLECTOR_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Sum,
  input  logic         Cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         err_overflow
);

  localparam int CW = credit_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [STAGES-1:0] tag_q, tag_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic              err_q, err_d;

  logic              issue;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [N:0]        fifo_head;
  logic [AW:0]       fifo_count;
  logic              unused_count;

  assign issue = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign push  = tag_q[STAGES-1];

  // Registered credits only: a returned credit is usable next cycle.
  assign in_ready     = (cred_q != '0);
  assign out_valid    = ~fifo_empty;
  assign out_cout     = fifo_head[N];
  assign out_sum      = fifo_head[N-1:0];
  assign err_overflow = err_q;
  assign unused_count = ^fifo_count;

  adder_result_fifo #(
    .WIDTH (N + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({Cout, Sum}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Tag shift, credit accounting and sticky overflow next-state.
  always_comb begin
    tag_d  = (tag_q << 1) | STAGES'(issue);
    cred_d = cred_q;
    unique case ({issue, pop})
      2'b10:   cred_d = cred_q - CW'(1);
      2'b01:   cred_d = cred_q + CW'(1);
      default: cred_d = cred_q;
    endcase
    err_d = err_q | (push & fifo_full & ~pop);
  end

  // Reset discards in-flight tags and restores the full credit pool.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= '0;
      cred_q <= CW'(DEPTH);
      err_q  <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      cred_q <= cred_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector with a 2-stage adder model.
// Popped results are logged at negedge and compared with hand-computed values.
module tb_adder_result_collector;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Sum;
  logic       Cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       err_overflow;

  logic [7:0] a_in, b_in;
  logic       cin;
  logic [8:0] p1_q, p2_q;

  logic [8:0] cap_q [$];
  int         cap_cyc [$];
  logic [8:0] exp_q [$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         acc;

  adder_result_collector #(
    .N      (8),
    .STAGES (2),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Sum          (Sum),
    .Cout         (Cout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-register adder model: operands at edge k appear after edge k+1.
  always @(posedge clk) begin
    if (reset) begin
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p1_q <= 9'(a_in) + 9'(b_in) + 9'(cin);
      p2_q <= p1_q;
    end
  end
  assign Sum  = p2_q[7:0];
  assign Cout = p2_q[8];

  // Log every handshake the DUT will see at the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && out_valid && out_ready) begin
      cap_q.push_back({out_cout, out_sum});
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = c;
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Single issue: 10+20, visible three cycles later for one cycle.
    out_ready = 1'b1;
    drive(1'b1, 8'd10, 8'd20, 1'b0);
    tick();
    drive(1'b0, 8'h55, 8'h77, 1'b1);
    check("single_c1", 32'(out_valid), 32'd0);
    tick();
    check("single_c2", 32'(out_valid), 32'd0);
    tick();
    check("single_c3_valid", 32'(out_valid), 32'd1);
    check("single_sum", 32'(out_sum), 32'd30);
    check("single_cout", 32'(out_cout), 32'd0);
    tick();
    check("single_c4", 32'(out_valid), 32'd0);
    repeat (3) tick();

    // Back-to-back issues.
    cap_q.delete();
    cap_cyc.delete();
    drive(1'b1, 8'd255, 8'd1, 1'b1);
    tick();
    drive(1'b1, 8'd128, 8'd128, 1'b0);
    tick();
    drive(1'b1, 8'd10, 8'd20, 1'b0);
    tick();
    drive(1'b0, 8'hAA, 8'h33, 1'b0);
    repeat (6) tick();
    check("b2b_count", 32'(cap_q.size()), 32'd3);
    check("b2b_r0", 32'(cap_q[0]), 32'h101);
    check("b2b_r1", 32'(cap_q[1]), 32'h100);
    check("b2b_r2", 32'(cap_q[2]), 32'h01E);
    check("b2b_gap01", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
    check("b2b_gap12", 32'(cap_cyc[2] - cap_cyc[1]), 32'd1);

    // Backpressure: only DEPTH issues accepted while out_ready is low.
    cap_q.delete();
    cap_cyc.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(3 * k), 8'(k), 1'b0);
      if (in_ready) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_in_ready_lo", 32'(in_ready), 32'd0);
    drive(1'b0, 8'h11, 8'h22, 1'b1);
    repeat (3) tick();
    check("bp_head_valid", 32'(out_valid), 32'd1);
    check("bp_head_sum", 32'(out_sum), 32'd4);
    tick();
    check("bp_head_hold", 32'(out_sum), 32'd4);
    out_ready = 1'b1;
    check("bp_no_comb_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    repeat (5) tick();
    check("bp_drain_count", 32'(cap_q.size()), 32'd4);
    check("bp_r0", 32'(cap_q[0]), 32'd4);
    check("bp_r1", 32'(cap_q[1]), 32'd8);
    check("bp_r2", 32'(cap_q[2]), 32'd12);
    check("bp_r3", 32'(cap_q[3]), 32'd16);
    check("bp_err", 32'(err_overflow), 32'd0);

    // Bubbles: idle adder outputs must never be captured.
    cap_q.delete();
    cap_cyc.delete();
    drive(1'b1, 8'd5, 8'd6, 1'b0);
    tick();
    drive(1'b0, 8'd99, 8'd99, 1'b1);
    tick();
    drive(1'b1, 8'd7, 8'd8, 1'b1);
    tick();
    drive(1'b0, 8'd200, 8'd100, 1'b0);
    repeat (6) tick();
    check("bub_count", 32'(cap_q.size()), 32'd2);
    check("bub_r0", 32'(cap_q[0]), 32'd11);
    check("bub_r1", 32'(cap_q[1]), 32'd16);

    // Fill the FIFO, then stream with issue and pop every cycle.
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'(10 * k), 8'(k), 1'b0);
      exp_q.push_back(9'(11 * k));
      tick();
    end
    drive(1'b0, 8'h3C, 8'hC3, 1'b1);
    repeat (3) tick();
    check("full_in_ready_lo", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(100 + k), 8'(2 * k), 1'(k & 1));
      if (in_ready) begin
        acc++;
        exp_q.push_back(9'(100 + 3 * k + (k & 1)));
      end
      tick();
    end
    drive(1'b0, 8'h0F, 8'hF0, 1'b0);
    repeat (6) tick();
    check("full_accepted", 32'(acc), 32'd9);
    check("full_count", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check("full_data", 32'(cap_q[i]), 32'(exp_q[i]));
    check("full_streaming",
          32'(cap_cyc[cap_cyc.size() - 1] - cap_cyc[0]),
          32'(cap_q.size() - 1));
    check("full_err", 32'(err_overflow), 32'd0);

    // Mid-operation reset with two queued and two in flight.
    cap_q.delete();
    cap_cyc.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'(k), 8'(k), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("mrst_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_err", 32'(err_overflow), 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    check("mrst_no_stale", 32'(cap_q.size()), 32'd0);
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(k), 8'd1, 1'b0);
      if (in_ready) acc++;
      tick();
    end
    check("mrst_credits", 32'(acc), 32'd4);
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
